// File: rtl/id_ex_stage_pkg.sv
// Shared CPU pipeline definitions: datapath widths, control-bundle layout,
// forwarding-select encodings and the ID/EX register record.
package id_ex_stage_pkg;

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 16;
  localparam int unsigned AW = 5;

  // Bit positions inside the opaque EX/MEM/WB control bundle (bits 13..15 reserved).
  localparam int unsigned CTRL_ALU_OP_LSB   = 0;
  localparam int unsigned CTRL_ALU_OP_W     = 4;
  localparam int unsigned CTRL_ALU_SRC      = 4;
  localparam int unsigned CTRL_MEM_WRITE    = 5;
  localparam int unsigned CTRL_MEM_TO_REG   = 6;
  localparam int unsigned CTRL_BRANCH       = 7;
  localparam int unsigned CTRL_JUMP         = 8;
  localparam int unsigned CTRL_MEM_SIZE_LSB = 9;
  localparam int unsigned CTRL_MEM_SIZE_W   = 2;
  localparam int unsigned CTRL_MEM_UNSIGNED = 11;
  localparam int unsigned CTRL_LINK         = 12;

  typedef logic [1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_RF  = 2'b00;
  localparam fwd_sel_t FWD_WB  = 2'b01;
  localparam fwd_sel_t FWD_MEM = 2'b10;

  // A later pipeline stage that may be writing a register this cycle.
  typedef struct packed {
    logic          regwrite;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } producer_t;

  // Contents of the ID/EX pipeline register.
  typedef struct packed {
    logic          valid;
    logic          regwrite;
    logic          memread;
    logic [AW-1:0] wr_addr;
    logic [CW-1:0] ctrl;
    logic [DW-1:0] rs_data;
    logic [DW-1:0] rt_data;
    logic [DW-1:0] imm;
    logic [DW-1:0] pc;
  } ex_reg_t;

  function automatic logic fwd_hit(input logic          regwrite,
                                   input logic [AW-1:0] prod_addr,
                                   input logic [AW-1:0] src_addr);
    return regwrite && (prod_addr == src_addr);
  endfunction

endpackage

// File: rtl/id_ex_stage_operand_bypass.sv
// Combinational operand bypass: picks the youngest in-flight producer of a
// source register, falling back to register-file data; r0 always reads zero.
module id_ex_stage_operand_bypass
  import id_ex_stage_pkg::*;
(
  input  logic [AW-1:0] src_addr,
  input  logic [DW-1:0] rf_data,
  input  producer_t     exmem,
  input  producer_t     memwb,
  output logic [DW-1:0] data,
  output fwd_sel_t      sel
);

  always_comb begin
    data = rf_data;
    sel  = FWD_RF;
    if (src_addr == '0) begin
      data = '0;
    end else if (fwd_hit(exmem.regwrite, exmem.addr, src_addr)) begin
      data = exmem.data;
      sel  = FWD_MEM;
    end else if (fwd_hit(memwb.regwrite, memwb.addr, src_addr)) begin
      // Register file has no write-through, so this path is the only way to
      // see a value being written back in the same cycle.
      data = memwb.data;
      sel  = FWD_WB;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand bypass, load-use bubble insertion,
// branch flush and downstream hold.
module id_ex_stage
  import id_ex_stage_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          id_valid,
  input  logic [AW-1:0] id_rs_addr,
  input  logic [AW-1:0] id_rt_addr,
  input  logic          id_use_rs,
  input  logic          id_use_rt,
  input  logic [DW-1:0] rf_data1,
  input  logic [DW-1:0] rf_data2,
  input  logic [AW-1:0] id_wr_addr,
  input  logic          id_regwrite,
  input  logic          id_memread,
  input  logic [CW-1:0] id_ctrl,
  input  logic [DW-1:0] id_imm,
  input  logic [DW-1:0] id_pc,
  input  logic          exmem_regwrite,
  input  logic [AW-1:0] exmem_addr,
  input  logic [DW-1:0] exmem_data,
  input  logic          memwb_regwrite,
  input  logic [AW-1:0] memwb_addr,
  input  logic [DW-1:0] memwb_data,
  input  logic          flush,
  input  logic          ex_hold,
  output logic          stall,
  output logic          ex_valid,
  output logic          ex_regwrite,
  output logic          ex_memread,
  output logic [DW-1:0] ex_rs_data,
  output logic [DW-1:0] ex_rt_data,
  output logic [DW-1:0] ex_imm,
  output logic [DW-1:0] ex_pc,
  output logic [AW-1:0] ex_wr_addr,
  output logic [CW-1:0] ex_ctrl
);

  producer_t     exmem_p;
  producer_t     memwb_p;
  logic [DW-1:0] rs_fwd;
  logic [DW-1:0] rt_fwd;
  fwd_sel_t      rs_sel;
  fwd_sel_t      rt_sel;
  ex_reg_t       ex_d;
  ex_reg_t       ex_q;
  logic          rs_match;
  logic          rt_match;
  logic          load_use;

  assign exmem_p = '{regwrite: exmem_regwrite, addr: exmem_addr, data: exmem_data};
  assign memwb_p = '{regwrite: memwb_regwrite, addr: memwb_addr, data: memwb_data};

  id_ex_stage_operand_bypass u_rs_bypass (
    .src_addr (id_rs_addr),
    .rf_data  (rf_data1),
    .exmem    (exmem_p),
    .memwb    (memwb_p),
    .data     (rs_fwd),
    .sel      (rs_sel)
  );

  id_ex_stage_operand_bypass u_rt_bypass (
    .src_addr (id_rt_addr),
    .rf_data  (rf_data2),
    .exmem    (exmem_p),
    .memwb    (memwb_p),
    .data     (rt_fwd),
    .sel      (rt_sel)
  );

  // The bypass never produces the unused encoding.
  always_comb begin
    assert ((rs_sel != 2'b11) && (rt_sel != 2'b11));
  end

  // A load in EX cannot feed ID through EX/MEM; ID waits one cycle and then
  // picks the value up from MEM/WB.
  assign rs_match = id_use_rs && (id_rs_addr == ex_q.wr_addr);
  assign rt_match = id_use_rt && (id_rt_addr == ex_q.wr_addr);
  assign load_use = id_valid && ex_q.valid && ex_q.memread && (ex_q.wr_addr != '0) &&
                    (rs_match || rt_match);

  assign stall = ex_hold || (load_use && !flush);

  always_comb begin
    ex_d = ex_q;
    if (ex_hold) begin
      // Frozen: operands captured earlier stay final, flush is ignored.
      ex_d = ex_q;
    end else if (flush || load_use) begin
      ex_d = '0;
    end else begin
      ex_d.valid    = id_valid;
      ex_d.regwrite = id_regwrite && id_valid;
      ex_d.memread  = id_memread && id_valid;
      ex_d.wr_addr  = id_wr_addr;
      ex_d.ctrl     = id_ctrl;
      ex_d.rs_data  = rs_fwd;
      ex_d.rt_data  = rt_fwd;
      ex_d.imm      = id_imm;
      ex_d.pc       = id_pc;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  assign ex_valid    = ex_q.valid;
  assign ex_regwrite = ex_q.regwrite;
  assign ex_memread  = ex_q.memread;
  assign ex_rs_data  = ex_q.rs_data;
  assign ex_rt_data  = ex_q.rt_data;
  assign ex_imm      = ex_q.imm;
  assign ex_pc       = ex_q.pc;
  assign ex_wr_addr  = ex_q.wr_addr;
  assign ex_ctrl     = ex_q.ctrl;

endmodule
